epb_pes_qstat: RTL and testbench

Parametrised successor to the EPB-to-PES link. It tracks per-queue packet and byte occupancy of the Egress Packet Buffer from EPB enqueue events and PES dequeue events. It presents a registered per-queue non-empty bitmap and a registered random-access count read port to the Packet Egress Scheduler. Dequeue completions are buffered in a return FIFO with valid/ready handshake back to the EPB for buffer release.

---
 rtl/epb_pes_qstat_if.sv | 54 +++++
 rtl/epb_pes_qstat.sv | 135 +++++++++++++
 tb/tb_epb_pes_qstat.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/epb_pes_qstat_if.sv
// Signal bundle between EPB/PES and the per-queue occupancy tracker.
// The slave modport is the tracker's view and the master modport is the view of the EPB/PES side.
interface epb_pes_qstat_if #(
    parameter int N_Q = 16,
    parameter int QW  = $clog2(N_Q),
    parameter int LW  = 14,
    parameter int PCW = 12,
    parameter int BCW = 24
);
    logic           enq_vld;
    logic [QW-1:0]  enq_q;
    logic [LW-1:0]  enq_len;
    logic           deq_vld;
    logic           deq_rdy;
    logic [QW-1:0]  deq_q;
    logic [LW-1:0]  deq_len;
    logic [N_Q-1:0] q_nonempty;
    logic [QW-1:0]  rd_q;
    logic [PCW-1:0] rd_pkt_cnt;
    logic [BCW-1:0] rd_byte_cnt;
    logic           rtn_vld;
    logic           rtn_rdy;
    logic [QW-1:0]  rtn_q;
    logic [LW-1:0]  rtn_len;
    logic           err_ovf;
    logic           err_unf;
    logic           err_clr;

    modport slave (
        input  enq_vld, enq_q, enq_len,
        input  deq_vld, deq_q, deq_len,
        output deq_rdy,
        output q_nonempty,
        input  rd_q,
        output rd_pkt_cnt, rd_byte_cnt,
        output rtn_vld, rtn_q, rtn_len,
        input  rtn_rdy,
        output err_ovf, err_unf,
        input  err_clr
    );

    modport master (
        output enq_vld, enq_q, enq_len,
        output deq_vld, deq_q, deq_len,
        input  deq_rdy,
        input  q_nonempty,
        output rd_q,
        input  rd_pkt_cnt, rd_byte_cnt,
        input  rtn_vld, rtn_q, rtn_len,
        output rtn_rdy,
        input  err_ovf, err_unf,
        output err_clr
    );
endinterface

// File: rtl/epb_pes_qstat.sv
// Per-queue packet/byte occupancy of the Egress Packet Buffer, with a non-empty bitmap,
// a registered count read port and a return FIFO that carries dequeue completions back to the EPB.
module epb_pes_qstat #(
    parameter int N_Q   = 16,
    parameter int QW    = $clog2(N_Q),
    parameter int LW    = 14,
    parameter int PCW   = 12,
    parameter int BCW   = 24,
    parameter int RTN_D = 8
) (
    input logic cclk,
    input logic rst_n,
    epb_pes_qstat_if.slave bus
);
    localparam int AW  = $clog2(RTN_D);
    localparam int PXW = PCW + 2;
    localparam int BXW = BCW + 2;
    localparam logic [PCW-1:0] PKT_MAX  = '1;
    localparam logic [BCW-1:0] BYTE_MAX = '1;

    logic [PCW-1:0] pkt_cnt  [N_Q];
    logic [PCW-1:0] pkt_nxt  [N_Q];
    logic [BCW-1:0] byte_cnt [N_Q];
    logic [BCW-1:0] byte_nxt [N_Q];
    logic [N_Q-1:0] nonempty_nxt;
    logic           enq_hit;
    logic           deq_hit;
    logic [PXW-1:0] pkt_ext;
    logic [BXW-1:0] byte_ext;
    logic           ovf_any;
    logic           unf_any;
    logic           ready_en;

    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [QW-1:0]  fifo_q   [RTN_D];
    logic [LW-1:0]  fifo_len [RTN_D];
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;

    // ready_en keeps deq_rdy low while in reset, even though the FIFO reads as empty then
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign bus.deq_rdy = ready_en && !fifo_full;
    assign push        = bus.deq_vld && bus.deq_rdy;
    assign bus.rtn_vld = !fifo_empty;
    assign pop         = bus.rtn_vld && bus.rtn_rdy;
    assign bus.rtn_q   = fifo_empty ? '0 : fifo_q[rd_ptr[AW-1:0]];
    assign bus.rtn_len = fifo_empty ? '0 : fifo_len[rd_ptr[AW-1:0]];

    // Net change per queue in two extra bits: top bit flags a negative result, next bit an overflow
    always_comb begin
        ovf_any      = 1'b0;
        unf_any      = 1'b0;
        enq_hit      = 1'b0;
        deq_hit      = 1'b0;
        pkt_ext      = '0;
        byte_ext     = '0;
        nonempty_nxt = '0;
        for (int i = 0; i < N_Q; i++) begin
            enq_hit  = bus.enq_vld && (bus.enq_q == QW'(i));
            deq_hit  = push && (bus.deq_q == QW'(i));
            pkt_ext  = PXW'(pkt_cnt[i]) + PXW'(enq_hit) - PXW'(deq_hit);
            byte_ext = BXW'(byte_cnt[i])
                     + (enq_hit ? BXW'(bus.enq_len) : '0)
                     - (deq_hit ? BXW'(bus.deq_len) : '0);

            if (pkt_ext[PCW+1]) begin
                pkt_nxt[i] = '0;
                unf_any    = 1'b1;
            end else if (pkt_ext[PCW]) begin
                pkt_nxt[i] = PKT_MAX;
                ovf_any    = 1'b1;
            end else begin
                pkt_nxt[i] = pkt_ext[PCW-1:0];
            end

            if (byte_ext[BCW+1]) begin
                byte_nxt[i] = '0;
                unf_any     = 1'b1;
            end else if (byte_ext[BCW]) begin
                byte_nxt[i] = BYTE_MAX;
                ovf_any     = 1'b1;
            end else begin
                byte_nxt[i] = byte_ext[BCW-1:0];
            end

            nonempty_nxt[i] = (pkt_nxt[i] != '0);
        end
    end

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_Q; i++) begin
                pkt_cnt[i]  <= '0;
                byte_cnt[i] <= '0;
            end
            bus.q_nonempty  <= '0;
            bus.rd_pkt_cnt  <= '0;
            bus.rd_byte_cnt <= '0;
            bus.err_ovf     <= 1'b0;
            bus.err_unf     <= 1'b0;
            ready_en        <= 1'b0;
        end else begin
            pkt_cnt         <= pkt_nxt;
            byte_cnt        <= byte_nxt;
            bus.q_nonempty  <= nonempty_nxt;
            bus.rd_pkt_cnt  <= pkt_nxt[bus.rd_q];
            bus.rd_byte_cnt <= byte_nxt[bus.rd_q];
            bus.err_ovf     <= ovf_any || (bus.err_ovf && !bus.err_clr);
            bus.err_unf     <= unf_any || (bus.err_unf && !bus.err_clr);
            ready_en        <= 1'b1;
        end
    end

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage needs no reset; the outputs are masked whenever the FIFO is empty
    always_ff @(posedge cclk) begin
        if (push) begin
            fifo_q[wr_ptr[AW-1:0]]   <= bus.deq_q;
            fifo_len[wr_ptr[AW-1:0]] <= bus.deq_len;
        end
    end
endmodule

// File: tb/tb_epb_pes_qstat.sv
// Bench for epb_pes_qstat: directed corner cases followed by random traffic, all checked
// against a behavioural model of counts and return entries.
module tb_epb_pes_qstat;
    localparam int N_Q   = 16;
    localparam int QW    = 4;
    localparam int LW    = 14;
    localparam int PCW   = 12;
    localparam int BCW   = 24;
    localparam int RTN_D = 8;
    localparam int PMAX  = (1 << PCW) - 1;
    localparam int BMAX  = (1 << BCW) - 1;

    typedef struct {
        int q;
        int len;
    } rtn_t;

    logic cclk  = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    int   m_pkt  [N_Q];
    int   m_byte [N_Q];
    bit   m_ovf;
    bit   m_unf;
    bit   m_rdy_en;
    int   m_rd_q;
    rtn_t m_fifo [$];

    epb_pes_qstat_if #(.N_Q(N_Q), .QW(QW), .LW(LW), .PCW(PCW), .BCW(BCW)) bus ();

    epb_pes_qstat #(
        .N_Q(N_Q), .QW(QW), .LW(LW), .PCW(PCW), .BCW(BCW), .RTN_D(RTN_D)
    ) dut (
        .cclk  (cclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 cclk = ~cclk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic modelClear();
        for (int q = 0; q < N_Q; q++) begin
            m_pkt[q]  = 0;
            m_byte[q] = 0;
        end
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_rdy_en = 1'b0;
        m_rd_q   = 0;
        m_fifo.delete();
    endtask

    // One clock: predict the effect of the driven inputs, then compare every output after the edge
    task automatic step();
        bit rdy, acc, pop, novf, nunf;
        int dp, db, np, nb;
        logic [N_Q-1:0] exp_ne;
        rtn_t ent;
        rdy = m_rdy_en && (m_fifo.size() < RTN_D);
        checkOutput("deq_rdy", 64'(bus.deq_rdy), 64'(rdy));
        acc  = bus.deq_vld && rdy;
        pop  = (m_fifo.size() != 0) && bus.rtn_rdy;
        novf = 1'b0;
        nunf = 1'b0;
        for (int q = 0; q < N_Q; q++) begin
            dp = 0;
            db = 0;
            if (bus.enq_vld && int'(bus.enq_q) == q) begin dp += 1; db += int'(bus.enq_len); end
            if (acc && int'(bus.deq_q) == q)         begin dp -= 1; db -= int'(bus.deq_len); end
            np = m_pkt[q] + dp;
            nb = m_byte[q] + db;
            if (np < 0) begin np = 0; nunf = 1'b1; end
            else if (np > PMAX) begin np = PMAX; novf = 1'b1; end
            if (nb < 0) begin nb = 0; nunf = 1'b1; end
            else if (nb > BMAX) begin nb = BMAX; novf = 1'b1; end
            m_pkt[q]  = np;
            m_byte[q] = nb;
        end
        m_rd_q = int'(bus.rd_q);
        if (pop) void'(m_fifo.pop_front());
        if (acc) begin
            ent.q   = int'(bus.deq_q);
            ent.len = int'(bus.deq_len);
            m_fifo.push_back(ent);
        end
        m_ovf = novf || (m_ovf && !bus.err_clr);
        m_unf = nunf || (m_unf && !bus.err_clr);

        @(posedge cclk);
        #1;
        exp_ne = '0;
        for (int q = 0; q < N_Q; q++) exp_ne[q] = (m_pkt[q] != 0);
        checkOutput("q_nonempty",  64'(bus.q_nonempty),  64'(exp_ne));
        checkOutput("rd_pkt_cnt",  64'(bus.rd_pkt_cnt),  64'(m_pkt[m_rd_q]));
        checkOutput("rd_byte_cnt", 64'(bus.rd_byte_cnt), 64'(m_byte[m_rd_q]));
        checkOutput("rtn_vld",     64'(bus.rtn_vld),     64'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            checkOutput("rtn_q",   64'(bus.rtn_q),   64'(m_fifo[0].q));
            checkOutput("rtn_len", 64'(bus.rtn_len), 64'(m_fifo[0].len));
        end
        checkOutput("err_ovf", 64'(bus.err_ovf), 64'(m_ovf));
        checkOutput("err_unf", 64'(bus.err_unf), 64'(m_unf));
    endtask

    task automatic applyStimulus(input bit ev, input int eq, input int el,
                                 input bit dv, input int dq, input int dl,
                                 input bit rr, input int rq, input bit ec);
        bus.enq_vld = ev;
        bus.enq_q   = QW'(eq);
        bus.enq_len = LW'(el);
        bus.deq_vld = dv;
        bus.deq_q   = QW'(dq);
        bus.deq_len = LW'(dl);
        bus.rtn_rdy = rr;
        bus.rd_q    = QW'(rq);
        bus.err_clr = ec;
        step();
    endtask

    task automatic setIdle();
        bus.enq_vld = 1'b0; bus.enq_q = '0; bus.enq_len = '0;
        bus.deq_vld = 1'b0; bus.deq_q = '0; bus.deq_len = '0;
        bus.rtn_rdy = 1'b0; bus.rd_q  = '0; bus.err_clr = 1'b0;
    endtask

    // Reset is asserted between clock edges so the asynchronous clear is seen on its own
    task automatic doReset();
        @(negedge cclk);
        setIdle();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_deq_rdy",  64'(bus.deq_rdy),     64'd0);
        checkOutput("rst_rtn_vld",  64'(bus.rtn_vld),     64'd0);
        checkOutput("rst_rtn_q",    64'(bus.rtn_q),       64'd0);
        checkOutput("rst_rtn_len",  64'(bus.rtn_len),     64'd0);
        checkOutput("rst_nonempty", 64'(bus.q_nonempty),  64'd0);
        checkOutput("rst_rd_pkt",   64'(bus.rd_pkt_cnt),  64'd0);
        checkOutput("rst_rd_byte",  64'(bus.rd_byte_cnt), 64'd0);
        checkOutput("rst_err_ovf",  64'(bus.err_ovf),     64'd0);
        checkOutput("rst_err_unf",  64'(bus.err_unf),     64'd0);
        modelClear();
        repeat (2) @(posedge cclk);
        @(negedge cclk);
        rst_n = 1'b1;
        @(posedge cclk);
        #1;
        m_rdy_en = 1'b1;
    endtask

    initial begin
        setIdle();
        modelClear();
        doReset();
        checkOutput("rdy_after_rst", 64'(bus.deq_rdy), 64'd1);

        applyStimulus(1, 5, 64,   0, 0, 0, 1, 5, 0);
        applyStimulus(1, 5, 128,  0, 0, 0, 1, 5, 0);
        applyStimulus(1, 5, 1500, 0, 0, 0, 1, 5, 0);
        checkOutput("q5_pkt",      64'(bus.rd_pkt_cnt),  64'd3);
        checkOutput("q5_byte",     64'(bus.rd_byte_cnt), 64'd1692);
        checkOutput("q5_nonempty", 64'(bus.q_nonempty),  64'h0020);

        applyStimulus(1, 2, 40,  0, 0, 0,  1, 2, 0);
        applyStimulus(1, 2, 100, 1, 2, 40, 0, 2, 0);
        checkOutput("same_q_pkt",  64'(bus.rd_pkt_cnt),    64'd1);
        checkOutput("same_q_byte", 64'(bus.rd_byte_cnt),   64'd100);
        checkOutput("same_q_ne",   64'(bus.q_nonempty[2]), 64'd1);
        checkOutput("same_q_rtnq", 64'(bus.rtn_q),         64'd2);
        checkOutput("same_q_rtnl", 64'(bus.rtn_len),       64'd40);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 2, 0);

        for (int k = 0; k < 8; k++) applyStimulus(1, 9, 10 + k, 0, 0, 0, 1, 9, 0);
        for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 1, 9, 10 + k, 0, 9, 0);
        checkOutput("full_rdy",  64'(bus.deq_rdy),    64'd0);
        checkOutput("full_pkt9", 64'(bus.rd_pkt_cnt), 64'd0);
        applyStimulus(0, 0, 0, 1, 9, 99, 0, 9, 0);
        checkOutput("held_head", 64'(bus.rtn_len), 64'd10);
        for (int k = 0; k < 8; k++) begin
            checkOutput("rtn_order", 64'(bus.rtn_len), 64'(10 + k));
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0);
            if (k == 0) checkOutput("rdy_after_pop", 64'(bus.deq_rdy), 64'd1);
        end
        checkOutput("drained", 64'(bus.rtn_vld), 64'd0);

        applyStimulus(0, 0, 0, 1, 7, 5, 0, 7, 0);
        checkOutput("unf_set",  64'(bus.err_unf),    64'd1);
        checkOutput("unf_pkt7", 64'(bus.rd_pkt_cnt), 64'd0);
        checkOutput("unf_rtnq", 64'(bus.rtn_q),      64'd7);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 1);
        checkOutput("unf_clr", 64'(bus.err_unf), 64'd0);
        applyStimulus(0, 0, 0, 1, 7, 5, 1, 7, 1);
        checkOutput("unf_clr_race", 64'(bus.err_unf), 64'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 1);

        applyStimulus(1, 3, 10, 0, 0, 0,  1, 3, 0);
        applyStimulus(0, 0, 0,  1, 3, 50, 1, 3, 0);
        checkOutput("bunf_byte", 64'(bus.rd_byte_cnt), 64'd0);
        checkOutput("bunf_err",  64'(bus.err_unf),     64'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);

        for (int k = 0; k < PMAX; k++) applyStimulus(1, 0, 1, 0, 0, 0, 1, 0, 0);
        checkOutput("pmax_pkt", 64'(bus.rd_pkt_cnt), 64'(PMAX));
        checkOutput("pmax_ovf", 64'(bus.err_ovf),    64'd0);
        applyStimulus(1, 0, 1, 0, 0, 0, 1, 0, 0);
        checkOutput("psat_pkt", 64'(bus.rd_pkt_cnt), 64'(PMAX));
        checkOutput("psat_ovf", 64'(bus.err_ovf),    64'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1);
        checkOutput("ovf_clr", 64'(bus.err_ovf), 64'd0);

        for (int k = 0; k < 1025; k++) applyStimulus(1, 1, 16383, 0, 0, 0, 1, 1, 0);
        checkOutput("bsat_byte", 64'(bus.rd_byte_cnt), 64'(BMAX));
        checkOutput("bsat_pkt",  64'(bus.rd_pkt_cnt),  64'd1025);
        checkOutput("bsat_ovf",  64'(bus.err_ovf),     64'd1);

        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1, 0, 1, 0, 0, 0);
        checkOutput("pre_rst_vld", 64'(bus.rtn_vld), 64'd1);
        doReset();
        checkOutput("post_rst_vld", 64'(bus.rtn_vld),    64'd0);
        checkOutput("post_rst_ne",  64'(bus.q_nonempty), 64'd0);

        for (int k = 0; k < 1500; k++) begin
            applyStimulus($urandom_range(1, 0) == 1, $urandom_range(N_Q - 1, 0), $urandom_range(16383, 0),
                          $urandom_range(1, 0) == 1, $urandom_range(N_Q - 1, 0), $urandom_range(2000, 0),
                          $urandom_range(3, 0) != 0, $urandom_range(N_Q - 1, 0), $urandom_range(15, 0) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
